// File: rtl/serial_adder.sv
// Purpose : bit-serial WIDTH-bit unsigned adder, LSB first, one bit per clock.
// Latency : WIDTH cycles from START acceptance to the DONE pulse; one addition per WIDTH+1 cycles.
// Backpr. : none; START is only accepted in IDLE/FIN and is ignored while BUSY is high.
//
// Ports: CLK/RST (async active-high), START + A/B operand load, BUSY (RUN state),
//        DONE (1-cycle pulse), S/C registered sum and carry-out, held until next completion,
//        OVF registered signed overflow (only when SERIAL_ADDER_OVF_EN is defined).

// Half adder cell: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             C
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             cy;

  // Structural full adder: two half adders plus an OR for the carry.
  logic s1, c1, c2, fa_sum, fa_cout;

  half_adder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s1),     .c(c1));
  half_adder u_ha1 (.a(s1),      .b(cy),      .s(fa_sum), .c(c2));
  assign fa_cout = c1 | c2;

  // Sum shift register after this bit is inserted; on the last bit this is the full result.
  logic [WIDTH-1:0] sum_next;
  assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      S      <= '0;
      C      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF    <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        // FIN accepts START exactly like IDLE so back-to-back operation loses no cycle.
        IDLE, FIN: begin
          if (START) begin
            a_sh   <= A;
            b_sh   <= B;
            sum_sh <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            BUSY   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          cy     <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            S     <= sum_next;
            C     <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // cy is the carry into the MSB at this point.
            OVF   <= cy ^ fa_cout;
`endif
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             C;
`ifdef SERIAL_ADDER_OVF_EN
  logic             OVF;
`endif

  serial_adder #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .C     (C)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dones = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    int               k;
  } exp_t;

  exp_t sb[$];

  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain integer addition, overflow from operand/result sign bits.
  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH:0] full;
    full  = {1'b0, a} + {1'b0, b};
    e.s   = full[WIDTH-1:0];
    e.c   = full[WIDTH];
    e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    e.k   = cyc;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every DONE must match the oldest pending addition.
  always @(negedge CLK) begin
    if (DONE) begin
      dones++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'(DONE), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", 64'(S), 64'(e.s));
        check("carry", 64'(C), 64'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(OVF), 64'(e.ovf));
`endif
        check("latency", 64'(cyc - e.k), 64'(WIDTH));
      end
    end
  end

  // Drive one START pulse; the bench is the one that knows the DUT is idle here.
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    START = 1'b1;
    @(posedge CLK);
    #1;
    push_exp(a, b);
    check("busy_after_accept", 64'(BUSY), 64'd1);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int d0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_s", 64'(S), 64'd0);
    check("rst_c", 64'(C), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 64'(OVF), 64'd0);
`endif
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Basic additions, including carry-out and signed overflow corners
    do_add(8'h5A, 8'h3C);
    wait_drain(30);
    do_add(8'hFF, 8'h01);
    wait_drain(30);
    do_add(8'h80, 8'h80);
    wait_drain(30);
    check("s_held", 64'(S), 64'h00);
    repeat (3) @(negedge CLK);
    check("s_held_later", 64'(S), 64'h00);
    check("c_held_later", 64'(C), 64'd1);

    // START and operand changes during RUN are ignored
    d0 = dones;
    do_add(8'h11, 8'h22);
    repeat (2) @(negedge CLK);
    A = 8'hFF;
    B = 8'hFF;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_drain(30);
    repeat (12) @(negedge CLK);
    check("single_done", 64'(dones - d0), 64'd1);
    check("s_ignored_start", 64'(S), 64'h33);

    // START held high: back-to-back every WIDTH+1 cycles, BUSY low only in FIN
    @(negedge CLK);
    A = 8'h01;
    B = 8'h02;
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      push_exp(8'h01, 8'h02);
      check("b2b_busy_run", 64'(BUSY), 64'd1);
      repeat (WIDTH) @(posedge CLK);
      #1;
      check("b2b_fin_busy", 64'(BUSY), 64'd0);
      check("b2b_fin_done", 64'(DONE), 64'd1);
    end
    @(negedge CLK);
    START = 1'b0;
    wait_drain(30);
    repeat (2) @(negedge CLK);
    check("b2b_idle_busy", 64'(BUSY), 64'd0);

    // Reset mid-RUN aborts with no DONE
    d0 = dones;
    do_add(8'h33, 8'h44);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    check("abort_s", 64'(S), 64'd0);
    check("abort_c", 64'(C), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", 64'(OVF), 64'd0);
`endif
    sb.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check("abort_no_done", 64'(dones - d0), 64'd0);

    do_add(8'h07, 8'h09);
    wait_drain(30);
    check("post_abort_s", 64'(S), 64'h10);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
